// File: rtl/pow_pkg.sv
// Shared types and constants for the square-and-multiply power unit.
package pow_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        CONV = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int BCD_W = 4;

    // Decimal digits of 2^pw - 1: floor(pw * log10(2)) + 1.
    function automatic int min_digits(input int pw);
        return (pw * 30103) / 100000 + 1;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per cycle,
// o_valid pulses exactly PW edges after i_start is sampled.
module bin2bcd_seq
    import pow_pkg::*;
#(
    parameter int PW     = 32,
    parameter int DIGITS = 10
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_start,
    input  logic [PW-1:0]             i_bin,
    output logic [BCD_W*DIGITS-1:0]   o_bcd,
    output logic                      o_valid
);

    localparam int CW = $clog2(PW + 1);
    localparam int BW = BCD_W * DIGITS;

    logic [PW-1:0] bin_q, bin_d;
    logic [BW-1:0] bcd_q, bcd_d, bcd_adj;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          valid_q, valid_d;

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[i*BCD_W +: BCD_W] >= 4'd5)
                bcd_adj[i*BCD_W +: BCD_W] = bcd_q[i*BCD_W +: BCD_W] + 4'd3;
        end

        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        if (i_start) begin
            bin_d = i_bin;
            bcd_d = '0;
            cnt_d = CW'(PW);
        end else if (cnt_q != '0) begin
            bcd_d   = {bcd_adj[BW-2:0], bin_q[PW-1]};
            bin_d   = {bin_q[PW-2:0], 1'b0};
            cnt_d   = cnt_q - CW'(1);
            valid_d = (cnt_q == CW'(1));
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    assign o_bcd   = bcd_q;
    assign o_valid = valid_q;

endmodule

// File: rtl/pow_unit.sv
// Sequential P = X^A (right-to-left square-and-multiply, one exponent bit per
// cycle) with overflow saturate/wrap and a BCD copy of the result.
module pow_unit
    import pow_pkg::*;
#(
    parameter int XW     = 8,
    parameter int AW     = 8,
    parameter int PW     = 32,
    parameter int DIGITS = 10,
    parameter int SAT    = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_start,
    input  logic [XW-1:0]           i_X,
    input  logic [AW-1:0]           i_A,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_ovf,
    output logic [PW-1:0]           o_P,
    output logic [BCD_W*DIGITS-1:0] o_bcd
);

    localparam int NMAX = (AW > PW) ? AW : PW;
    localparam int CW   = $clog2(NMAX + 1);
    localparam int BW   = BCD_W * DIGITS;

    if (DIGITS < min_digits(PW)) begin : g_digits_check
        $error("pow_unit: DIGITS too small to hold 2^PW-1");
    end

    state_t        state_q, state_d;
    logic [PW-1:0] base_q, base_d, result_q, result_d;
    logic [AW-1:0] exp_q, exp_d;
    logic          r_ovf_q, r_ovf_d, b_ovf_q, b_ovf_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2*PW-1:0] mul_r, mul_b;
    logic          conv_start, conv_valid;
    logic [PW-1:0] conv_bin;
    logic [BW-1:0] conv_bcd;
    logic          done_q, ovf_q;
    logic [PW-1:0] p_q;
    logic [BW-1:0] bcd_q;

    assign mul_r = {{PW{1'b0}}, result_q} * {{PW{1'b0}}, base_q};
    assign mul_b = {{PW{1'b0}}, base_q} * {{PW{1'b0}}, base_q};

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        result_d   = result_q;
        exp_d      = exp_q;
        r_ovf_d    = r_ovf_q;
        b_ovf_d    = b_ovf_q;
        cnt_d      = cnt_q;
        conv_start = 1'b0;
        case (state_q)
            IDLE: if (i_start) begin
                base_d   = PW'(i_X);
                exp_d    = i_A;
                result_d = PW'(1);
                r_ovf_d  = 1'b0;
                b_ovf_d  = 1'b0;
                cnt_d    = '0;
                state_d  = CALC;
            end
            CALC: begin
                // A poisoned base only matters if it is actually multiplied in.
                if (exp_q[0]) begin
                    result_d = mul_r[PW-1:0];
                    r_ovf_d  = r_ovf_q | (|mul_r[2*PW-1:PW]) | b_ovf_q;
                end
                base_d  = mul_b[PW-1:0];
                b_ovf_d = b_ovf_q | (|mul_b[2*PW-1:PW]);
                exp_d   = exp_q >> 1;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(AW - 1)) begin
                    state_d    = CONV;
                    cnt_d      = '0;
                    conv_start = 1'b1;
                end
            end
            CONV: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(PW - 1))
                    state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        conv_bin = ((SAT != 0) && r_ovf_d) ? '1 : result_d;
    end

    bin2bcd_seq #(.PW(PW), .DIGITS(DIGITS)) u_bcd (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_start (conv_start),
        .i_bin   (conv_bin),
        .o_bcd   (conv_bcd),
        .o_valid (conv_valid)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            base_q   <= '0;
            result_q <= '0;
            exp_q    <= '0;
            r_ovf_q  <= 1'b0;
            b_ovf_q  <= 1'b0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            p_q      <= '0;
            bcd_q    <= '0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            result_q <= result_d;
            exp_q    <= exp_d;
            r_ovf_q  <= r_ovf_d;
            b_ovf_q  <= b_ovf_d;
            cnt_q    <= cnt_d;
            done_q   <= (state_q == DONE);
            if (state_q == DONE && conv_valid) begin
                ovf_q <= r_ovf_q;
                p_q   <= ((SAT != 0) && r_ovf_q) ? '1 : result_q;
                bcd_q <= conv_bcd;
            end
        end
    end

    assign o_busy = (state_q == CALC) || (state_q == CONV);
    assign o_done = done_q;
    assign o_ovf  = ovf_q;
    assign o_P    = p_q;
    assign o_bcd  = bcd_q;

endmodule

// File: tb/tb_pow_unit.sv
// Directed table-driven bench for pow_unit; runs a saturating and a wrapping
// instance side by side on the same stimulus.
module tb_pow_unit;

    localparam int XW = 8, AW = 8, PW = 32, DIGITS = 10, BW = 4 * DIGITS;
    localparam int LAT = AW + PW + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [XW-1:0] x;
    logic [AW-1:0] a;
    logic          busy_s, done_s, ovf_s, busy_w, done_w, ovf_w;
    logic [PW-1:0] p_s, p_w;
    logic [BW-1:0] bcd_s, bcd_w;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pow_unit #(.XW(XW), .AW(AW), .PW(PW), .DIGITS(DIGITS), .SAT(1)) dut_sat (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_X(x), .i_A(a),
        .o_busy(busy_s), .o_done(done_s), .o_ovf(ovf_s), .o_P(p_s), .o_bcd(bcd_s)
    );

    pow_unit #(.XW(XW), .AW(AW), .PW(PW), .DIGITS(DIGITS), .SAT(0)) dut_wrap (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_X(x), .i_A(a),
        .o_busy(busy_w), .o_done(done_w), .o_ovf(ovf_w), .o_P(p_w), .o_bcd(bcd_w)
    );

    typedef struct {
        logic [XW-1:0] x;
        logic [AW-1:0] a;
        logic [PW-1:0] p_sat;
        logic [BW-1:0] bcd_sat;
        logic [PW-1:0] p_wrap;
        logic [BW-1:0] bcd_wrap;
        logic          ovf;
    } vec_t;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse_start(input logic [XW-1:0] xv, input logic [AW-1:0] av);
        @(negedge clk);
        x = xv;
        a = av;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts edges after the sampling edge until o_done is seen; -1 on timeout.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            #1;
            if (done_s) begin
                lat = n;
                break;
            end
        end
    endtask

    vec_t vecs[13];

    initial begin
        int lat;
        vecs[0]  = '{8'd3,   8'd5,   32'd243,        80'h243,        32'd243,        80'h243,        1'b0};
        vecs[1]  = '{8'd0,   8'd0,   32'd1,          80'h1,          32'd1,          80'h1,          1'b0};
        vecs[2]  = '{8'd0,   8'd7,   32'd0,          80'h0,          32'd0,          80'h0,          1'b0};
        vecs[3]  = '{8'd2,   8'd31,  32'd2147483648, 80'h2147483648, 32'd2147483648, 80'h2147483648, 1'b0};
        vecs[4]  = '{8'd2,   8'd32,  32'hFFFFFFFF,   80'h4294967295, 32'd0,          80'h0,          1'b1};
        vecs[5]  = '{8'd255, 8'd4,   32'd4228250625, 80'h4228250625, 32'd4228250625, 80'h4228250625, 1'b0};
        vecs[6]  = '{8'd255, 8'd5,   32'hFFFFFFFF,   80'h4294967295, 32'd167118079,  80'h167118079,  1'b1};
        vecs[7]  = '{8'd1,   8'd255, 32'd1,          80'h1,          32'd1,          80'h1,          1'b0};
        vecs[8]  = '{8'd10,  8'd9,   32'd1000000000, 80'h1000000000, 32'd1000000000, 80'h1000000000, 1'b0};
        vecs[9]  = '{8'd16,  8'd8,   32'hFFFFFFFF,   80'h4294967295, 32'd0,          80'h0,          1'b1};
        vecs[10] = '{8'd7,   8'd11,  32'd1977326743, 80'h1977326743, 32'd1977326743, 80'h1977326743, 1'b0};
        vecs[11] = '{8'd3,   8'd20,  32'd3486784401, 80'h3486784401, 32'd3486784401, 80'h3486784401, 1'b0};
        vecs[12] = '{8'd3,   8'd21,  32'hFFFFFFFF,   80'h4294967295, 32'd1870418611, 80'h1870418611, 1'b1};

        rst_n = 1'b0;
        start = 1'b0;
        x = '0;
        a = '0;
        #12;
        check("reset_busy", busy_s, 1'b0);
        check("reset_done", done_s, 1'b0);
        check("reset_ovf",  ovf_s,  1'b0);
        check("reset_p",    p_s,    '0);
        check("reset_bcd",  bcd_s,  '0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            pulse_start(vecs[i].x, vecs[i].a);
            wait_done(lat);
            check($sformatf("v%0d_latency", i), lat, LAT);
            check($sformatf("v%0d_done_wrap", i), done_w, 1'b1);
            check($sformatf("v%0d_busy_in_done", i), busy_s, 1'b0);
            check($sformatf("v%0d_p_sat", i), p_s, vecs[i].p_sat);
            check($sformatf("v%0d_bcd_sat", i), bcd_s, vecs[i].bcd_sat);
            check($sformatf("v%0d_ovf_sat", i), ovf_s, vecs[i].ovf);
            check($sformatf("v%0d_p_wrap", i), p_w, vecs[i].p_wrap);
            check($sformatf("v%0d_bcd_wrap", i), bcd_w, vecs[i].bcd_wrap);
            check($sformatf("v%0d_ovf_wrap", i), ovf_w, vecs[i].ovf);
            @(posedge clk);
            #1 check($sformatf("v%0d_done_falls", i), done_s, 1'b0);
        end

        // Back-to-back: start accepted in the o_done cycle itself.
        pulse_start(8'd2, 8'd10);
        wait_done(lat);
        @(negedge clk);
        x = 8'd3;
        a = 8'd3;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("b2b_busy", busy_s, 1'b1);
        wait_done(lat);
        check("b2b_latency", lat, LAT);
        check("b2b_p", p_s, 32'd27);

        // Re-pulsed start during CALC must be ignored.
        pulse_start(8'd3, 8'd5);
        repeat (2) @(posedge clk);
        #1 check("calc_busy", busy_s, 1'b1);
        @(negedge clk);
        x = 8'd2;
        a = 8'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        check("restart_latency", lat, LAT - 3);
        check("restart_p", p_s, 32'd243);
        check("restart_bcd", bcd_s, 80'h243);

        // Reset in the middle of CONV clears everything; next op is clean.
        pulse_start(8'd7, 8'd11);
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy_s, 1'b0);
        check("midrst_p",    p_s,    '0);
        check("midrst_bcd",  bcd_s,  '0);
        check("midrst_ovf",  ovf_s,  1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("midrst_no_done", done_s, 1'b0);
        pulse_start(8'd255, 8'd5);
        wait_done(lat);
        check("postrst_latency", lat, LAT);
        check("postrst_p_sat", p_s, 32'hFFFFFFFF);
        check("postrst_p_wrap", p_w, 32'd167118079);
        check("postrst_ovf", ovf_s, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
